// File: rtl/control_smoother_if.sv
// Frame-ready strobe, raw control words and smoothed engine controls for control_smoother.
`timescale 1ns/1ps
interface control_smoother_if #(
  parameter int DIV_BIT = 11
);
  logic               i_Data_Received;
  logic [15:0]        i_Data0;
  logic [15:0]        i_Data1;
  logic [15:0]        i_Data2;
  logic [15:0]        i_Data3;
  logic [15:0]        i_Data4;
  logic [15:0]        i_Data5;
  logic [15:0]        o_Frequency;
  logic [DIV_BIT-1:0] o_Harmonic_Scale_0;
  logic [DIV_BIT-1:0] o_Scale_Initial_0;
  logic [DIV_BIT-1:0] o_Harmonic_Scale_1;
  logic [DIV_BIT-1:0] o_Scale_Initial_1;
  logic [15:0]        o_Freq_Scale;
  logic               o_Update;
  logic               o_Busy;

  modport master (
    output i_Data_Received, i_Data0, i_Data1, i_Data2, i_Data3, i_Data4, i_Data5,
    input  o_Frequency, o_Harmonic_Scale_0, o_Scale_Initial_0, o_Harmonic_Scale_1,
           o_Scale_Initial_1, o_Freq_Scale, o_Update, o_Busy
  );

  modport slave (
    input  i_Data_Received, i_Data0, i_Data1, i_Data2, i_Data3, i_Data4, i_Data5,
    output o_Frequency, o_Harmonic_Scale_0, o_Scale_Initial_0, o_Harmonic_Scale_1,
           o_Scale_Initial_1, o_Freq_Scale, o_Update, o_Busy
  );
endinterface

// File: rtl/control_smoother.sv
// Snapshots six ADC control words per frame, low-pass filters them one channel per
// clock through a shared datapath, then commits all six smoothed values in one cycle.
`timescale 1ns/1ps
module control_smoother #(
  parameter int DIV_BIT = 11,
  parameter int SHIFT   = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  control_smoother_if.slave bus
);
  localparam int AW = 16 + SHIFT;

  typedef enum logic [1:0] {IDLE, FILTER, COMMIT} state_t;

  state_t          state;
  logic            r_Prev;
  logic            pending;
  logic            primed;
  logic [2:0]      chan;
  logic [15:0]     cap [6];
  logic [AW-1:0]   acc [6];

  logic            edge_seen;
  logic [AW-1:0]   acc_sel;
  logic [AW-1:0]   in_sel;
  logic [AW-1:0]   acc_next;

  // Intermediate sum may wrap in AW bits; the true result always fits, so modulo arithmetic is exact.
  always_comb begin
    edge_seen = bus.i_Data_Received & ~r_Prev;
    acc_sel   = acc[chan];
    in_sel    = AW'(cap[chan]);
    acc_next  = primed ? (acc_sel + in_sel - (acc_sel >> SHIFT)) : (in_sel << SHIFT);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state                  <= IDLE;
      r_Prev                 <= 1'b0;
      pending                <= 1'b0;
      primed                 <= 1'b0;
      chan                   <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        cap[i] <= '0;
        acc[i] <= '0;
      end
      bus.o_Frequency        <= 16'd90;
      bus.o_Harmonic_Scale_0 <= '0;
      bus.o_Scale_Initial_0  <= '0;
      bus.o_Harmonic_Scale_1 <= '0;
      bus.o_Scale_Initial_1  <= '0;
      bus.o_Freq_Scale       <= '0;
      bus.o_Update           <= 1'b0;
      bus.o_Busy             <= 1'b0;
    end else begin
      r_Prev       <= bus.i_Data_Received;
      bus.o_Update <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_seen || pending) begin
            cap[0]     <= bus.i_Data0;
            cap[1]     <= 16'(bus.i_Data1[DIV_BIT-1:0]);
            cap[2]     <= 16'(bus.i_Data2[DIV_BIT-1:0]);
            cap[3]     <= 16'(bus.i_Data3[DIV_BIT-1:0]);
            cap[4]     <= 16'(bus.i_Data4[DIV_BIT-1:0]);
            cap[5]     <= bus.i_Data5;
            pending    <= 1'b0;
            chan       <= '0;
            bus.o_Busy <= 1'b1;
            state      <= FILTER;
          end
        end
        FILTER: begin
          acc[chan] <= acc_next;
          if (edge_seen) pending <= 1'b1;
          if (chan == 3'd5) state <= COMMIT;
          else              chan  <= chan + 3'd1;
        end
        COMMIT: begin
          bus.o_Frequency        <= 16'(acc[0] >> SHIFT);
          bus.o_Harmonic_Scale_0 <= DIV_BIT'(acc[1] >> SHIFT);
          bus.o_Scale_Initial_0  <= DIV_BIT'(acc[2] >> SHIFT);
          bus.o_Harmonic_Scale_1 <= DIV_BIT'(acc[3] >> SHIFT);
          bus.o_Scale_Initial_1  <= DIV_BIT'(acc[4] >> SHIFT);
          bus.o_Freq_Scale       <= 16'(acc[5] >> SHIFT);
          bus.o_Update           <= 1'b1;
          bus.o_Busy             <= 1'b0;
          primed                 <= 1'b1;
          if (edge_seen) pending <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_control_smoother.sv
// Directed bench for control_smoother: SHIFT=2 instance for filtering/timing, SHIFT=0 for pass-through.
`timescale 1ns/1ps
module tb_control_smoother;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  control_smoother_if #(.DIV_BIT(11)) ifa ();
  control_smoother_if #(.DIV_BIT(11)) ifb ();

  control_smoother #(.DIV_BIT(11), .SHIFT(2)) dut_a (.i_Clock(clk), .i_Reset_n(rst_n), .bus(ifa.slave));
  control_smoother #(.DIV_BIT(11), .SHIFT(0)) dut_b (.i_Clock(clk), .i_Reset_n(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Raises frame-ready for one cycle on dut_a; lat = clocks from capture edge to o_Update, -1 on timeout.
  task automatic send_frame(output int lat, output logic busy0);
    @(negedge clk);
    ifa.i_Data_Received = 1'b1;
    @(posedge clk); #1;
    busy0 = ifa.o_Busy;
    @(negedge clk);
    ifa.i_Data_Received = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ifa.o_Update === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0;
    ifa.i_Data_Received = 1'b0;
    ifb.i_Data_Received = 1'b0;
    {ifa.i_Data0, ifa.i_Data1, ifa.i_Data2, ifa.i_Data3, ifa.i_Data4, ifa.i_Data5} = '0;
    {ifb.i_Data0, ifb.i_Data1, ifb.i_Data2, ifb.i_Data3, ifb.i_Data4, ifb.i_Data5} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ifa.o_Update !== 1'b0 || ifa.o_Busy !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL reset_quiet got update/busy activity want none"); end
    tests++; if (ifa.o_Frequency !== 16'd90) begin fails++; $display("FAIL reset_freq got %0d want 90", ifa.o_Frequency); end
    tests++; if (ifa.o_Harmonic_Scale_0 !== 11'd0 || ifa.o_Scale_Initial_0 !== 11'd0 ||
                 ifa.o_Harmonic_Scale_1 !== 11'd0 || ifa.o_Scale_Initial_1 !== 11'd0 ||
                 ifa.o_Freq_Scale !== 16'd0) begin
      fails++; $display("FAIL reset_others got %0d %0d %0d %0d %0d want all 0", ifa.o_Harmonic_Scale_0,
                        ifa.o_Scale_Initial_0, ifa.o_Harmonic_Scale_1, ifa.o_Scale_Initial_1, ifa.o_Freq_Scale);
    end
    tests++; if (ifb.o_Frequency !== 16'd90) begin fails++; $display("FAIL reset_freq_b got %0d want 90", ifb.o_Frequency); end
  endtask

  task automatic test_first_frame();
    int lat; logic busy0;
    ifa.i_Data0 = 16'd1000;
    ifa.i_Data1 = 16'hFFFF;
    send_frame(lat, busy0);
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL first_busy_high got %0b want 1", busy0); end
    tests++; if (lat !== 7) begin fails++; $display("FAIL first_latency got %0d want 7", lat); end
    tests++; if (ifa.o_Frequency !== 16'd1000) begin fails++; $display("FAIL first_freq got %0d want 1000", ifa.o_Frequency); end
    tests++; if (ifa.o_Harmonic_Scale_0 !== 11'd2047) begin fails++; $display("FAIL first_scale0 got %0d want 2047", ifa.o_Harmonic_Scale_0); end
    tests++; if (ifa.o_Busy !== 1'b0) begin fails++; $display("FAIL first_busy_low got %0b want 0", ifa.o_Busy); end
    @(posedge clk); #1;
    tests++; if (ifa.o_Update !== 1'b0) begin fails++; $display("FAIL first_single_pulse got %0b want 0", ifa.o_Update); end
  endtask

  task automatic test_filtering();
    int lat; logic busy0;
    ifa.i_Data0 = 16'd2000;
    send_frame(lat, busy0);
    tests++; if (lat !== 7 || ifa.o_Frequency !== 16'd1250) begin fails++; $display("FAIL filt_step1 got %0d (lat %0d) want 1250", ifa.o_Frequency, lat); end
    send_frame(lat, busy0);
    tests++; if (lat !== 7 || ifa.o_Frequency !== 16'd1437) begin fails++; $display("FAIL filt_step2 got %0d (lat %0d) want 1437", ifa.o_Frequency, lat); end
    for (int n = 0; n < 40; n++) send_frame(lat, busy0);
    tests++; if (lat !== 7 || ifa.o_Frequency !== 16'd2000) begin fails++; $display("FAIL filt_converge got %0d (lat %0d) want 2000", ifa.o_Frequency, lat); end
    tests++; if (ifa.o_Harmonic_Scale_0 !== 11'd2047) begin fails++; $display("FAIL filt_scale0_hold got %0d want 2047", ifa.o_Harmonic_Scale_0); end
  endtask

  task automatic test_back_to_back();
    int n, p1, p2;
    logic [15:0] f1, f2;
    n = 0; p1 = -1; p2 = -1; f1 = '0; f2 = '0;
    @(negedge clk);
    ifa.i_Data_Received = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      case (cyc)
        1: ifa.i_Data_Received = 1'b0;
        3: ifa.i_Data_Received = 1'b1;
        4: ifa.i_Data_Received = 1'b0;
        5: ifa.i_Data_Received = 1'b1;
        6: begin ifa.i_Data_Received = 1'b0; ifa.i_Data0 = 16'd3000; end
        default: ;
      endcase
      @(posedge clk); #1;
      if (ifa.o_Update === 1'b1) begin
        n++;
        if (n == 1) begin p1 = cyc; f1 = ifa.o_Frequency; end
        if (n == 2) begin p2 = cyc; f2 = ifa.o_Frequency; end
      end
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL b2b_pulse_count got %0d want 2", n); end
    tests++; if (p1 !== 7 || p2 !== 15) begin fails++; $display("FAIL b2b_pulse_times got %0d,%0d want 7,15", p1, p2); end
    tests++; if (f1 !== 16'd2000) begin fails++; $display("FAIL b2b_freq1 got %0d want 2000", f1); end
    tests++; if (f2 !== 16'd2250) begin fails++; $display("FAIL b2b_freq2 got %0d want 2250", f2); end
  endtask

  task automatic test_mid_reset();
    int lat; logic busy0, bad;
    ifa.i_Data0 = 16'd5000;
    @(negedge clk);
    ifa.i_Data_Received = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.i_Data_Received = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (ifa.o_Frequency !== 16'd90 || ifa.o_Busy !== 1'b0 || ifa.o_Update !== 1'b0) begin
      fails++; $display("FAIL midrst_values got freq %0d busy %0b upd %0b want 90 0 0", ifa.o_Frequency, ifa.o_Busy, ifa.o_Update);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ifa.o_Update !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad !== 1'b0 || ifa.o_Frequency !== 16'd90) begin fails++; $display("FAIL midrst_no_update got freq %0d upd_seen %0b want 90 0", ifa.o_Frequency, bad); end
    ifa.i_Data0 = 16'd3000;
    send_frame(lat, busy0);
    tests++; if (lat !== 7 || ifa.o_Frequency !== 16'd3000) begin fails++; $display("FAIL midrst_direct_load got %0d (lat %0d) want 3000", ifa.o_Frequency, lat); end
  endtask

  task automatic test_shift0();
    logic [15:0] vin  [2][6];
    logic [15:0] vexp [2][6];
    logic [15:0] obs  [6];
    int lat;
    vin[0]  = '{16'd1234, 16'hF123, 16'h0000, 16'h07FF, 16'h0800, 16'hABCD};
    vexp[0] = '{16'd1234, 16'h0123, 16'h0000, 16'h07FF, 16'h0000, 16'hABCD};
    vin[1]  = '{16'd77,   16'h0005, 16'hFFFF, 16'h0001, 16'h0FFF, 16'h0000};
    vexp[1] = '{16'd77,   16'h0005, 16'h07FF, 16'h0001, 16'h07FF, 16'h0000};
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      ifb.i_Data0 = vin[f][0]; ifb.i_Data1 = vin[f][1]; ifb.i_Data2 = vin[f][2];
      ifb.i_Data3 = vin[f][3]; ifb.i_Data4 = vin[f][4]; ifb.i_Data5 = vin[f][5];
      ifb.i_Data_Received = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifb.i_Data_Received = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (ifb.o_Update === 1'b1) begin lat = k; break; end
      end
      tests++; if (lat !== 7) begin fails++; $display("FAIL shift0_latency frame %0d got %0d want 7", f, lat); end
      obs[0] = ifb.o_Frequency;
      obs[1] = 16'(ifb.o_Harmonic_Scale_0);
      obs[2] = 16'(ifb.o_Scale_Initial_0);
      obs[3] = 16'(ifb.o_Harmonic_Scale_1);
      obs[4] = 16'(ifb.o_Scale_Initial_1);
      obs[5] = ifb.o_Freq_Scale;
      for (int c = 0; c < 6; c++) begin
        tests++;
        if (obs[c] !== vexp[f][c]) begin fails++; $display("FAIL shift0_ch%0d frame %0d got %h want %h", c, f, obs[c], vexp[f][c]); end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_frame();
    test_filtering();
    test_back_to_back();
    test_mid_reset();
    test_shift0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
